// File: rtl/snoopy_cpu_controller.sv
// CPU-side sequencer of the snoopy cache: victim write-back, invalidate, block fill, state commit.
// Optional hit/miss counters are enabled with `define SNOOPY_CPU_CONTROLLER_STATISTICS_EN.
module snoopy_cpu_controller #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int OFFSET_WIDTH  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_read,
    input  logic                     cpu_write,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    output logic                     cpu_function_complete,
    input  logic                     hit,
    input  logic                     write_back_required,
    input  logic                     invalidate_required,
    input  logic                     read_exclusive_required,
    input  logic [ADDRESS_WIDTH-1:0] victim_address,
    output logic [OFFSET_WIDTH-1:0]  cache_offset,
    output logic                     cache_data_write,
    output logic                     cache_fill_select,
    output logic                     cache_tag_write,
    output logic                     cache_state_write,
    output logic [DATA_WIDTH-1:0]    cache_fill_data,
    output logic                     bus_request,
    input  logic                     bus_grant,
    output logic [2:0]               bus_command,
    output logic [ADDRESS_WIDTH-1:0] bus_address,
    input  logic                     bus_ack,
    input  logic [DATA_WIDTH-1:0]    bus_data_in
`ifdef SNOOPY_CPU_CONTROLLER_STATISTICS_EN
    ,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_GRANT,
        S_WRITE_BACK,
        S_FILL,
        S_INVALIDATE,
        S_COMMIT
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE           = 3'd0,
        CMD_READ           = 3'd1,
        CMD_READ_EXCLUSIVE = 3'd2,
        CMD_INVALIDATE     = 3'd3,
        CMD_WRITE_BACK     = 3'd4
    } bus_cmd_t;

    state_t                  r_state;
    state_t                  r_pending;
    bus_cmd_t                r_fill_cmd;
    logic [OFFSET_WIDTH-1:0] r_counter;

    state_t                  w_next_state;
    logic [OFFSET_WIDTH-1:0] w_next_counter;
    logic                    w_request;
    logic                    w_last_word;
    logic                    w_unused_victim_offset;

    assign w_request              = cpu_read | cpu_write;
    assign w_last_word            = (r_counter == '1);
    assign cache_fill_data        = bus_data_in;
    // Victim is block-aligned, so its offset bits carry no information.
    assign w_unused_victim_offset = ^victim_address[OFFSET_WIDTH-1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pending  <= S_FILL;
            r_fill_cmd <= CMD_READ;
            r_counter  <= '0;
        end else begin
            r_state   <= w_next_state;
            r_counter <= w_next_counter;
            if (r_state == S_IDLE && w_request) begin
                r_pending  <= hit ? S_INVALIDATE :
                              (write_back_required ? S_WRITE_BACK : S_FILL);
                r_fill_cmd <= read_exclusive_required ? CMD_READ_EXCLUSIVE : CMD_READ;
            end
        end
    end

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        w_next_state          = r_state;
        w_next_counter        = r_counter;
        cpu_function_complete = 1'b0;
        cache_offset          = '0;
        cache_data_write      = 1'b0;
        cache_fill_select     = 1'b0;
        cache_tag_write       = 1'b0;
        cache_state_write     = 1'b0;
        bus_request           = 1'b0;
        bus_command           = CMD_NONE;
        bus_address           = '0;

        case (r_state)
            S_IDLE: begin
                if (w_request) begin
                    w_next_state = (hit && !invalidate_required) ? S_COMMIT : S_WAIT_GRANT;
                end
            end
            S_WAIT_GRANT: begin
                bus_request = 1'b1;
                if (bus_grant) begin
                    w_next_state = r_pending;
                end
            end
            S_WRITE_BACK: begin
                bus_request  = 1'b1;
                bus_command  = CMD_WRITE_BACK;
                bus_address  = {victim_address[ADDRESS_WIDTH-1:OFFSET_WIDTH], r_counter};
                cache_offset = r_counter;
                if (bus_ack) begin
                    w_next_counter = w_last_word ? '0 : r_counter + OFFSET_WIDTH'(1);
                    if (w_last_word) begin
                        w_next_state = S_FILL;
                    end
                end
            end
            S_FILL: begin
                bus_request       = 1'b1;
                bus_command       = r_fill_cmd;
                bus_address       = {cpu_address[ADDRESS_WIDTH-1:OFFSET_WIDTH], r_counter};
                cache_offset      = r_counter;
                cache_fill_select = 1'b1;
                cache_data_write  = bus_ack;
                if (bus_ack) begin
                    w_next_counter = w_last_word ? '0 : r_counter + OFFSET_WIDTH'(1);
                    if (w_last_word) begin
                        cache_tag_write = 1'b1;
                        w_next_state    = S_COMMIT;
                    end
                end
            end
            S_INVALIDATE: begin
                bus_request = 1'b1;
                bus_command = CMD_INVALIDATE;
                bus_address = cpu_address;
                if (bus_ack) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                cache_state_write     = 1'b1;
                cpu_function_complete = 1'b1;
                if (cpu_write) begin
                    cache_data_write = 1'b1;
                    cache_offset     = cpu_address[OFFSET_WIDTH-1:0];
                end
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

`ifdef SNOOPY_CPU_CONTROLLER_STATISTICS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == S_IDLE && w_request) begin
            if (hit && r_hit_count != 16'hFFFF) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (!hit && r_miss_count != 16'hFFFF) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
